// File: rtl/ps2_tx_pkg.sv
// Shared types and timing defaults for the PS/2 host-to-device transmitter.
// No logic; pure declarations.
package ps2_tx_pkg;

  typedef enum logic [2:0] {
    IDLE,
    INHIBIT,
    RTS,
    SEND,
    ACK,
    RELEASE,
    DONE,
    ERR
  } tx_state_t;

  localparam int DEF_CLK_HZ     = 50_000_000;
  localparam int INHIBIT_US     = 120;
  localparam int START_MS       = 15;
  localparam int PACKET_MS      = 2;
  localparam int DEF_FILTER_LEN = 4;
  localparam int FRAME_BITS     = 10;

  function automatic logic odd_parity(input logic [7:0] d);
    return ~^d;
  endfunction

endpackage

// File: rtl/ps2_line_sync.sv
// PS/2 line conditioner: 2-flop synchroniser, FILTER_LEN-sample glitch filter, falling-edge pulse.
// Latency pin->level/fall is 2+FILTER_LEN cycles; no backpressure.
module ps2_line_sync #(
  parameter int FILTER_LEN = 4
) (
  input  logic core_clk,
  input  logic arst_n,
  input  logic pin,
  output logic synced,
  output logic level,
  output logic fall
);

  localparam int CW = $clog2(FILTER_LEN + 1);

  logic [1:0]    sync_q;
  logic [CW-1:0] cnt_q;

  assign synced = sync_q[1];

  // Lines idle high, so reset to 1 to avoid a spurious edge after reset.
  always_ff @(posedge core_clk or negedge arst_n) begin
    if (!arst_n) begin
      sync_q <= 2'b11;
      cnt_q  <= '0;
      level  <= 1'b1;
      fall   <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], pin};
      fall   <= 1'b0;
      if (sync_q[1] == level) begin
        cnt_q <= '0;
      end else if (cnt_q == CW'(FILTER_LEN - 1)) begin
        level <= sync_q[1];
        cnt_q <= '0;
        fall  <= ~sync_q[1];
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device command transmitter: inhibit, request-to-send, 11-bit frame, ACK check.
// One byte per handshake; cmd_ready only in IDLE, cmd_valid elsewhere is ignored (no queueing).
module ps2_host_tx
  import ps2_tx_pkg::*;
#(
  parameter int CLK_HZ         = DEF_CLK_HZ,
  parameter int INHIBIT_CYCLES = CLK_HZ / 1_000_000 * INHIBIT_US,
  parameter int START_TIMEOUT  = CLK_HZ / 1000 * START_MS,
  parameter int PACKET_TIMEOUT = CLK_HZ / 1000 * PACKET_MS,
  parameter int FILTER_LEN     = DEF_FILTER_LEN
) (
  input  logic       CLOCK_50,
  input  logic       reset_n,
  input  logic [7:0] cmd_data,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic       ps2_clk_in,
  input  logic       ps2_dat_in,
  output logic       ps2_clk_drive_low,
  output logic       ps2_dat_drive_low,
  output logic       rx_inhibit,
  output logic       cmd_done,
  output logic       cmd_error
);

  // One shared timer, sized for the longest interval it has to measure.
  localparam int TMAX_A = (START_TIMEOUT > PACKET_TIMEOUT) ? START_TIMEOUT : PACKET_TIMEOUT;
  localparam int TMAX   = (TMAX_A > INHIBIT_CYCLES) ? TMAX_A : INHIBIT_CYCLES;
  localparam int TW     = $clog2(TMAX + 1);

  localparam logic [TW-1:0] INH_T   = TW'(INHIBIT_CYCLES);
  localparam logic [TW-1:0] START_T = TW'(START_TIMEOUT);
  localparam logic [TW-1:0] PKT_T   = TW'(PACKET_TIMEOUT);

  tx_state_t                 state_q, state_nxt;
  logic [TW-1:0]             timer_q, timer_nxt;
  logic [3:0]                bitcnt_q, bitcnt_nxt;
  logic [FRAME_BITS-1:0]     shreg_q, shreg_nxt;
  logic                      dat_low_q, dat_low_nxt;
  logic                      clk_low_q;
  logic                      ack_q, ack_nxt;
  logic [1:0]                dat_sync_q;
  logic                      dat_s;
  logic                      clk_level;
  logic                      clk_fall;
  logic                      clk_synced;

  ps2_line_sync #(
    .FILTER_LEN(FILTER_LEN)
  ) u_clk_sync (
    .core_clk(CLOCK_50),
    .arst_n  (reset_n),
    .pin     (ps2_clk_in),
    .synced  (clk_synced),
    .level   (clk_level),
    .fall    (clk_fall)
  );

  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) dat_sync_q <= 2'b11;
    else          dat_sync_q <= {dat_sync_q[0], ps2_dat_in};
  end

  assign dat_s = dat_sync_q[1];

  always_comb begin
    state_nxt   = state_q;
    timer_nxt   = (timer_q == '1) ? timer_q : timer_q + 1'b1;
    bitcnt_nxt  = bitcnt_q;
    shreg_nxt   = shreg_q;
    dat_low_nxt = dat_low_q;
    ack_nxt     = ack_q;

    unique case (state_q)
      IDLE: begin
        timer_nxt = '0;
        if (cmd_valid) begin
          shreg_nxt  = {1'b1, odd_parity(cmd_data), cmd_data};
          bitcnt_nxt = '0;
          state_nxt  = INHIBIT;
        end
      end
      INHIBIT: begin
        // DAT joins CLK low for the final inhibit cycle only.
        if (timer_q == INH_T - 1'b1) dat_low_nxt = 1'b1;
        if (timer_q == INH_T) begin
          state_nxt = RTS;
          timer_nxt = '0;
        end
      end
      RTS: begin
        if (clk_fall) begin
          dat_low_nxt = ~shreg_q[0];
          shreg_nxt   = {1'b0, shreg_q[FRAME_BITS-1:1]};
          bitcnt_nxt  = 4'd1;
          timer_nxt   = '0;
          state_nxt   = SEND;
        end else if (timer_q >= START_T) begin
          state_nxt = ERR;
        end
      end
      SEND: begin
        if (timer_q >= PKT_T) begin
          state_nxt = ERR;
        end else if (clk_fall) begin
          if (bitcnt_q == 4'd10) begin
            ack_nxt   = dat_s;
            state_nxt = ACK;
          end else begin
            dat_low_nxt = ~shreg_q[0];
            shreg_nxt   = {1'b0, shreg_q[FRAME_BITS-1:1]};
            bitcnt_nxt  = bitcnt_q + 4'd1;
          end
        end
      end
      ACK: begin
        if (timer_q >= PKT_T) state_nxt = ERR;
        else                  state_nxt = ack_q ? ERR : RELEASE;
      end
      RELEASE: begin
        if (timer_q >= PKT_T)          state_nxt = ERR;
        else if (clk_level && dat_s)   state_nxt = DONE;
      end
      DONE:    state_nxt = IDLE;
      ERR:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase

    if (!(state_nxt inside {INHIBIT, RTS, SEND})) dat_low_nxt = 1'b0;
  end

  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      timer_q   <= '0;
      bitcnt_q  <= '0;
      shreg_q   <= '0;
      dat_low_q <= 1'b0;
      clk_low_q <= 1'b0;
      ack_q     <= 1'b1;
    end else begin
      state_q   <= state_nxt;
      timer_q   <= timer_nxt;
      bitcnt_q  <= bitcnt_nxt;
      shreg_q   <= shreg_nxt;
      dat_low_q <= dat_low_nxt;
      clk_low_q <= (state_nxt == INHIBIT);
      ack_q     <= ack_nxt;
    end
  end

  assign ps2_clk_drive_low = clk_low_q;
  assign ps2_dat_drive_low = dat_low_q;
  assign cmd_ready         = (state_q == IDLE);
  assign rx_inhibit        = (state_q != IDLE);
  assign cmd_done          = (state_q == DONE);
  assign cmd_error         = (state_q == ERR);

endmodule
